// File: rtl/wave_meter.sv
`default_nettype none
// ============================================================================
// Module   : wave_meter
// Purpose  : Measures the 8-bit DAC sample stream over a fixed gate window.
//            It counts rising mid-level crossings with hysteresis to estimate
//            frequency, and it tracks the minimum, maximum and peak-to-peak
//            code. Results are latched once per window, and o_valid pulses
//            for one cycle when they update.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            i_en            - run measurement (low = idle / abort window)
//            i_in_valid      - i_wave carries a new sample this cycle
//            i_wave          - unsigned DAC code
//            o_freq_count    - rising crossings in last completed window
//            o_ovf           - crossing counter saturated in last window
//            o_wave_max/min  - extreme samples in last window
//            o_vpp           - o_wave_max - o_wave_min
//            o_valid         - one-cycle pulse when results update
// Revision : 1.0 - initial release
// ============================================================================
module wave_meter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int MID         = 128,
  parameter int HYST        = 8,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_in_valid,
  input  logic [7:0]       i_wave,
  output logic [CNT_W-1:0] o_freq_count,
  output logic             o_ovf,
  output logic [7:0]       o_wave_max,
  output logic [7:0]       o_wave_min,
  output logic [7:0]       o_vpp,
  output logic             o_valid
);

  // Gate counter runs 0 .. GATE_CYCLES-1 inside a window.
  localparam int               c_gate_w    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
  // Thresholds are compared at 9 bits so MID+HYST above 255 stays meaningful.
  localparam logic [8:0]       c_thr_hi    = 9'(MID + HYST);
  localparam logic [8:0]       c_thr_lo    = 9'(MID - HYST);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LATCH   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_gate_w-1:0] r_gate;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_acc;
  logic [7:0]          r_max;
  logic [7:0]          r_min;
  logic                r_seen;     // at least one valid sample this window
  logic                r_hyst_hi;  // comparator state: 1 = HIGH, 0 = LOW

  logic w_rise;
  logic w_fall;
  logic w_cnt_full;

  assign w_rise     = !r_hyst_hi && ({1'b0, i_wave} >= c_thr_hi);
  assign w_fall     =  r_hyst_hi && ({1'b0, i_wave} <  c_thr_lo);
  assign w_cnt_full = (r_cnt == c_cnt_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gate       <= '0;
      r_cnt        <= '0;
      r_ovf_acc    <= 1'b0;
      r_max        <= 8'h00;
      r_min        <= 8'hFF;
      r_seen       <= 1'b0;
      r_hyst_hi    <= 1'b1;
      o_freq_count <= '0;
      o_ovf        <= 1'b0;
      o_wave_max   <= 8'h00;
      o_wave_min   <= 8'h00;
      o_vpp        <= 8'h00;
      o_valid      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_gate    <= '0;
          r_cnt     <= '0;
          r_ovf_acc <= 1'b0;
          r_max     <= 8'h00;
          r_min     <= 8'hFF;
          r_seen    <= 1'b0;
          // Start HIGH so the first counted crossing needs a genuine low phase.
          r_hyst_hi <= 1'b1;
          if (i_en) begin
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (!i_en) begin
            // Abort: outputs untouched; IDLE clears the accumulators.
            r_state <= ST_IDLE;
          end else begin
            r_gate <= r_gate + 1'b1;
            if (r_gate == c_gate_last) begin
              r_state <= ST_LATCH;
            end
            if (i_in_valid) begin
              r_seen <= 1'b1;
              if (i_wave > r_max) r_max <= i_wave;
              if (i_wave < r_min) r_min <= i_wave;
              if (w_rise) begin
                r_hyst_hi <= 1'b1;
                if (w_cnt_full) begin
                  r_ovf_acc <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end else if (w_fall) begin
                r_hyst_hi <= 1'b0;
              end
            end
          end
        end

        ST_LATCH: begin
          o_freq_count <= r_cnt;
          o_ovf        <= r_ovf_acc;
          if (r_seen) begin
            o_wave_max <= r_max;
            o_wave_min <= r_min;
            o_vpp      <= r_max - r_min;
          end else begin
            o_wave_max <= 8'h00;
            o_wave_min <= 8'h00;
            o_vpp      <= 8'h00;
          end
          o_valid   <= 1'b1;
          // Hysteresis state carries over so consecutive windows see one waveform.
          r_gate    <= '0;
          r_cnt     <= '0;
          r_ovf_acc <= 1'b0;
          r_max     <= 8'h00;
          r_min     <= 8'hFF;
          r_seen    <= 1'b0;
          r_state   <= i_en ? ST_MEASURE : ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_meter
// Purpose  : Self-checking bench for wave_meter. Expected window results are
//            queued when a window's stimulus starts and are popped when the
//            valid pulse arrives. A second instance with a 4-bit counter
//            covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_meter;

  localparam int GATE = 100;

  typedef struct packed {
    logic [23:0] freq;
    logic        ovf;
    logic [7:0]  mx;
    logic [7:0]  mn;
    logic [7:0]  vpp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  wave;

  logic [23:0] freq_count;
  logic        ovf;
  logic [7:0]  wave_max, wave_min, vpp;
  logic        valid;

  logic [3:0]  s_freq_count;
  logic        s_ovf;
  logic [7:0]  s_wave_max, s_wave_min, s_vpp;
  logic        s_valid;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t exp_sat_q[$];

  always #5 clk = ~clk;

  wave_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .CNT_W(24)) u_dut (
    .clk(clk), .rst(rst), .i_en(en), .i_in_valid(in_valid), .i_wave(wave),
    .o_freq_count(freq_count), .o_ovf(ovf), .o_wave_max(wave_max),
    .o_wave_min(wave_min), .o_vpp(vpp), .o_valid(valid)
  );

  wave_meter #(.GATE_CYCLES(GATE), .MID(128), .HYST(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .i_en(en), .i_in_valid(in_valid), .i_wave(wave),
    .o_freq_count(s_freq_count), .o_ovf(s_ovf), .o_wave_max(s_wave_max),
    .o_wave_min(s_wave_min), .o_vpp(s_vpp), .o_valid(s_valid)
  );

  // valid must never be high on two consecutive cycles.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (prev_valid) begin
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_twice: valid=%b on cycle after a pulse, required 0", valid);
      end
    end
    prev_valid = valid;
  end

  function automatic res_t mk(int f, bit o, int mx, int mn, int v);
    res_t r;
    r.freq = 24'(f);
    r.ovf  = o;
    r.mx   = 8'(mx);
    r.mn   = 8'(mn);
    r.vpp  = 8'(v);
    return r;
  endfunction

  function automatic res_t obs_main();
    return {freq_count, ovf, wave_max, wave_min, vpp};
  endfunction

  function automatic res_t obs_sat();
    return {20'd0, s_freq_count, s_ovf, s_wave_max, s_wave_min, s_vpp};
  endfunction

  // Stimulus patterns indexed by position inside the window.
  // 0 square 5/5, 1 triangle 124..132, 2 const 200, 3 no valid samples,
  // 4 alternate 0/255, 5 const 0, 6 threshold edges, 7 single late crossing
  function automatic logic [7:0] samp(int mode, int k);
    int p;
    logic [7:0] thr [6];
    thr = '{8'd119, 8'd136, 8'd120, 8'd136, 8'd119, 8'd135};
    case (mode)
      0: return ((k % 10) < 5) ? 8'd0 : 8'd255;
      1: begin
        p = k % 16;
        return (p <= 8) ? 8'(124 + p) : 8'(140 - p);
      end
      2: return 8'd200;
      3: return 8'd77;
      4: return ((k % 2) == 0) ? 8'd0 : 8'd255;
      6: return thr[k % 6];
      7: return (k == GATE - 1) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  // Clock edge that takes the FSM from IDLE into MEASURE.
  task automatic enter();
    en = 1'b1;
    in_valid = 1'b1;
    wave = 8'd0;
    tick();
  endtask

  // GATE measure cycles followed by the LATCH cycle. The LATCH-cycle sample
  // is 0 on purpose: it must not reach the accumulators.
  task automatic run_window(input int mode, output logic got_valid, output int early,
                            output res_t r, output res_t rs);
    early = 0;
    for (int k = 0; k < GATE; k++) begin
      in_valid = (mode != 3);
      wave = samp(mode, k);
      tick();
      if (valid) early++;
    end
    in_valid = 1'b1;
    wave = 8'd0;
    tick();
    got_valid = valid;
    r  = obs_main();
    rs = obs_sat();
  endtask

  // Clocks from the current point until valid shows up, bounded.
  task automatic clocks_to_valid(output int n, output bit found);
    n = 0;
    found = 0;
    while (n < 200 && !found) begin
      tick();
      n++;
      if (valid) found = 1;
    end
  endtask

  task automatic test_reset();
    logic gv; int early; res_t r, rs, e; int n; bit found;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; wave = 8'd0;
    repeat (3) tick();
    checks++;
    if (obs_main() !== res_t'(0) || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %h valid=%b, required 0 valid=0", obs_main(), valid);
    end
    rst = 1'b0;
    tick();
    enter();
    exp_q.push_back(mk(10, 0, 255, 0, 255));
    run_window(0, gv, early, r, rs);
    e = exp_q.pop_front();
    checks++;
    if (gv !== 1'b1 || early != 0 || r !== e) begin
      errors++;
      $display("FAIL reset_pre_window: got %h valid=%b early=%0d, required %h valid=1 early=0", r, gv, early, e);
    end
    for (int k = 0; k < 50; k++) begin
      wave = samp(0, k);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_main() !== res_t'(0) || obs_sat() !== res_t'(0) || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got %h/%h valid=%b, required 0/0 valid=0", obs_main(), obs_sat(), valid);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b1;
    wave = 8'd0;
    clocks_to_valid(n, found);
    checks++;
    if (!found || n != 102) begin
      errors++;
      $display("FAIL reset_first_valid: got %0d clocks (found=%0d), required 102", n, found);
    end
    go_idle();
  endtask

  task automatic test_square_back_to_back();
    logic gv; int early; res_t r, rs, e;
    go_idle();
    enter();
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back(mk(10, 0, 255, 0, 255));
      run_window(0, gv, early, r, rs);
      e = exp_q.pop_front();
      checks++;
      if (gv !== 1'b1 || early != 0 || r !== e) begin
        errors++;
        $display("FAIL square_win%0d: got %h valid=%b early=%0d, required %h valid=1 early=0", w, r, gv, early, e);
      end
    end
  endtask

  task automatic test_patterns();
    logic gv; int early; res_t r, rs, e;
    int modes [4];
    modes = '{1, 2, 6, 7};
    exp_q.push_back(mk(0, 0, 132, 124, 8));
    exp_q.push_back(mk(0, 0, 200, 200, 0));
    exp_q.push_back(mk(17, 0, 136, 119, 17));
    exp_q.push_back(mk(1, 0, 255, 0, 255));
    foreach (modes[i]) begin
      go_idle();
      enter();
      run_window(modes[i], gv, early, r, rs);
      e = exp_q.pop_front();
      checks++;
      if (gv !== 1'b1 || early != 0 || r !== e) begin
        errors++;
        $display("FAIL pattern_mode%0d: got %h valid=%b early=%0d, required %h", modes[i], r, gv, early, e);
      end
    end
  endtask

  task automatic test_no_samples();
    logic gv; int early; res_t r, rs, e;
    go_idle();
    enter();
    exp_q.push_back(mk(0, 0, 200, 200, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int w = 0; w < 2; w++) begin
      run_window((w == 0) ? 2 : 3, gv, early, r, rs);
      e = exp_q.pop_front();
      checks++;
      if (gv !== 1'b1 || r !== e) begin
        errors++;
        $display("FAIL no_samples_win%0d: got %h valid=%b, required %h valid=1", w, r, gv, e);
      end
    end
  endtask

  task automatic test_abort();
    logic gv; int early; res_t r, rs, e; int nv; int n; bit found;
    go_idle();
    enter();
    exp_q.push_back(mk(10, 0, 255, 0, 255));
    run_window(0, gv, early, r, rs);
    e = exp_q.pop_front();
    checks++;
    if (gv !== 1'b1 || r !== e) begin
      errors++;
      $display("FAIL abort_first: got %h valid=%b, required %h valid=1", r, gv, e);
    end
    for (int k = 0; k < 50; k++) begin
      wave = samp(0, k);
      tick();
    end
    en = 1'b0;
    nv = 0;
    repeat (120) begin
      tick();
      if (valid) nv++;
    end
    checks++;
    if (nv != 0 || obs_main() !== e) begin
      errors++;
      $display("FAIL abort_hold: got %h pulses=%0d, required %h pulses=0", obs_main(), nv, e);
    end
    en = 1'b1;
    wave = 8'd0;
    clocks_to_valid(n, found);
    checks++;
    if (!found || n != 102) begin
      errors++;
      $display("FAIL abort_idle_restart: got %0d clocks (found=%0d), required 102", n, found);
    end
  endtask

  task automatic test_saturate();
    logic gv; int early; res_t r, rs, e, es;
    go_idle();
    enter();
    exp_q.push_back(mk(50, 0, 255, 0, 255));
    exp_sat_q.push_back(mk(15, 1, 255, 0, 255));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_sat_q.push_back(mk(0, 0, 0, 0, 0));
    for (int w = 0; w < 2; w++) begin
      run_window((w == 0) ? 4 : 5, gv, early, r, rs);
      e  = exp_q.pop_front();
      es = exp_sat_q.pop_front();
      checks++;
      if (gv !== 1'b1 || r !== e) begin
        errors++;
        $display("FAIL sat_wide_win%0d: got %h valid=%b, required %h valid=1", w, r, gv, e);
      end
      checks++;
      if (s_valid !== 1'b1 || rs !== es) begin
        errors++;
        $display("FAIL sat_narrow_win%0d: got %h valid=%b, required %h valid=1", w, rs, s_valid, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square_back_to_back();
    test_patterns();
    test_no_samples();
    test_abort();
    test_saturate();
    go_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wave_meter.md
# wave_meter

Measurement block on the receive side of the 8-bit DAC sample stream that the DDS top drives out on `toDAC`. It samples the waveform code every qualified clock and, over a fixed gate window, counts rising mid-level crossings with hysteresis (a frequency estimate) and tracks minimum, maximum and peak-to-peak code. Results are latched once per window, with a one-cycle `valid` pulse. It serves as an on-chip self-check of the generator and as the reference monitor in DDS simulation benches.

## Interface
- `GATE_CYCLES`, default 1000000: clocks per measurement window (10 ms at 100 MHz); minimum 2.
- `MID`, default 128: crossing threshold code.
- `HYST`, default 8: hysteresis half-width; low threshold `MID-HYST`, high threshold `MID+HYST`.
- `CNT_W`, default 24: width of the crossing counter.

- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run measurement; low = idle/abort.
- `in_valid` in 1: `wave` holds a new sample this cycle.
- `wave` in 8: unsigned DAC code.
- `freq_count` out CNT_W: rising crossings in the last completed window.
- `ovf` out 1: crossing counter saturated in the last completed window.
- `wave_max` out 8: maximum sample in the last window.
- `wave_min` out 8: minimum sample in the last window.
- `vpp` out 8: `wave_max - wave_min`.
- `valid` out 1: one-cycle pulse when the results update.

## Operation
- The control FSM has three states: IDLE, MEASURE, LATCH.
- IDLE:
  - The gate counter, accumulators and hysteresis state are cleared. Hysteresis state is set to HIGH, so the first counted crossing must first go below the low threshold.
  - Moves to MEASURE on the first clock with `en=1`.
- MEASURE:
  - The gate counter increments every clock. Every cycle with `in_valid=1` updates the accumulators.
  - After the GATE_CYCLES-th clock, moves to LATCH.
  - `en=0` in any MEASURE cycle aborts to IDLE: no `valid` pulse, and the latched outputs keep their previous values.
- LATCH (one cycle):
  - Copies the accumulators to the outputs and asserts `valid`.
  - Clears the accumulators and gate counter, but keeps the hysteresis state, so back-to-back windows see a continuous waveform.
  - Returns to MEASURE if `en=1`, otherwise to IDLE.
- Hysteresis comparator, updated only on `in_valid` samples:
  - LOW→HIGH when `wave >= MID+HYST`. This transition increments the crossing count.
  - HIGH→LOW when `wave < MID-HYST`.
  - Samples between the thresholds leave the state unchanged.
- The crossing count saturates at 2^CNT_W-1 and sets the window's `ovf` accumulator. It never wraps.
- Min/max accumulators start each window at min=255, max=0. If a window has no valid samples, it latches `wave_max=0`, `wave_min=0`, `vpp=0`.
- `vpp` is computed from the latched max and min, 8-bit unsigned, and is never negative.

## Timing
- Reset values: `freq_count=0`, `ovf=0`, `wave_max=0`, `wave_min=0`, `vpp=0`, `valid=0`, FSM in IDLE.
- `rst` acts asynchronously mid-window, discarding the window.
- Window timing:
  - `en` is sampled high at edge t, so the first MEASURE cycle is t+1.
  - The window covers exactly GATE_CYCLES clocks of samples.
  - LATCH follows immediately. Outputs and `valid` are registered, so they change at the edge ending LATCH and are visible for the one cycle after it.
- The window period is GATE_CYCLES+1 clocks. The LATCH-cycle sample is not measured.
- A sample that crosses in the last MEASURE cycle counts in that window.
- `en` falling during the LATCH cycle still produces that window's `valid` pulse.
- `valid` is never high for two consecutive cycles.

## Test plan
All scenarios use `GATE_CYCLES=100`, `MID=128`, `HYST=8`, `in_valid=1` unless stated.
- Reset: assert `rst` mid-window → all outputs 0 immediately and no `valid` pulse; after release with `en=1`, the first `valid` arrives 102 clocks later.
- Square wave, 5 clocks at 0 then 5 at 255 (period 10), starting low at window start → `freq_count=10`, `wave_max=255`, `wave_min=0`, `vpp=255`, `ovf=0`, with one `valid` every 101 clocks.
- Triangle 124↔132, staying inside the hysteresis band → `freq_count=0`, `wave_max=132`, `wave_min=124`, `vpp=8`.
- Constant 200 → `freq_count=0`, max = min = 200, `vpp=0`. Then `in_valid=0` for a whole window → max/min/`vpp` = 0.
- Complete one window with the square wave (count 10), then drop `en` at MEASURE cycle 50 of the next window → no `valid`, outputs stay at 10/255/0/255, FSM returns to IDLE.
- `CNT_W=4`, square wave of period 2 (0,255 alternating) → 50 crossings saturate: `freq_count=15`, `ovf=1`. The next window of constant 0 gives `ovf=0`, `freq_count=0`.
